// File: rtl/balance_arbiter.sv
// Round-robin arbiter granting three terminals exclusive access to one shared
// 64-bit account balance (deposit with saturation, withdrawal with funds check).
module balance_arbiter #(
  parameter logic [63:0] INIT_BALANCE = 64'd4500,
  parameter int          N_REQ        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] tipo_trans,
  input  logic [31:0]      monto_0,
  input  logic [31:0]      monto_1,
  input  logic [31:0]      monto_2,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             fondos_insuficientes,
  output logic [63:0]      balance,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t           state, state_n;
  logic [N_REQ-1:0] grant_n, done_n;
  logic             fondos_n, busy_n;
  logic [63:0]      balance_n;
  logic [1:0]       winner, winner_n;
  logic [1:0]       last_winner, last_winner_n;
  logic [1:0]       pick;
  logic             latch;
  logic             op_tipo;
  logic [31:0]      op_monto;
  logic [31:0]      monto_pick;

  function automatic logic [63:0] sat_add(input logic [63:0] bal, input logic [31:0] amt);
    logic [64:0] sum;
    sum = {1'b0, bal} + {33'd0, amt};
    return sum[64] ? {64{1'b1}} : sum[63:0];
  endfunction

  // Nearest requester after last_winner wins; scanning farthest-first lets the
  // closest candidate overwrite the others.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] last);
    logic [1:0] p;
    int         c;
    p = last;
    for (int k = N_REQ; k >= 1; k--) begin
      c = (int'(last) + k) % N_REQ;
      if (r[c]) p = 2'(c);
    end
    return p;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  always_comb begin
    case (pick)
      2'd0:    monto_pick = monto_0;
      2'd1:    monto_pick = monto_1;
      default: monto_pick = monto_2;
    endcase
  end

  always_comb begin
    pick          = rr_pick(req, last_winner);
    state_n       = state;
    grant_n       = grant;
    done_n        = done;
    fondos_n      = fondos_insuficientes;
    balance_n     = balance;
    winner_n      = winner;
    last_winner_n = last_winner;
    latch         = 1'b0;
    case (state)
      IDLE: begin
        grant_n  = '0;
        done_n   = '0;
        fondos_n = 1'b0;
        if (|req) begin
          state_n       = GRANT;
          grant_n       = onehot(pick);
          winner_n      = pick;
          last_winner_n = pick;
          latch         = 1'b1;
        end
      end
      GRANT: begin
        state_n = RESP;
        done_n  = onehot(winner);
        if (!op_tipo) begin
          balance_n = sat_add(balance, op_monto);
          fondos_n  = 1'b0;
        end else if ({32'd0, op_monto} > balance) begin
          fondos_n  = 1'b1;
        end else begin
          balance_n = balance - {32'd0, op_monto};
          fondos_n  = 1'b0;
        end
      end
      RESP: begin
        if (!req[winner]) begin
          state_n  = IDLE;
          grant_n  = '0;
          done_n   = '0;
          fondos_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      grant                <= '0;
      done                 <= '0;
      fondos_insuficientes <= 1'b0;
      balance              <= INIT_BALANCE;
      busy                 <= 1'b0;
      winner               <= 2'd0;
      last_winner          <= 2'd2;
    end else begin
      state                <= state_n;
      grant                <= grant_n;
      done                 <= done_n;
      fondos_insuficientes <= fondos_n;
      balance              <= balance_n;
      busy                 <= busy_n;
      winner               <= winner_n;
      last_winner          <= last_winner_n;
    end
  end

  // Operand capture: frozen at the grant edge so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch) begin
      op_tipo  <= tipo_trans[pick];
      op_monto <= monto_pick;
    end
  end

endmodule

// File: tb/tb_balance_arbiter.sv
// Bench for balance_arbiter: transaction-level reference model checked every
// cycle, directed literal scenarios, then randomized request traffic.
module tb_balance_arbiter;

  localparam logic [63:0] MAXV     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_INIT = 64'hFFFF_FFFC_FFFF_FF9E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0, tipo = '0;
  logic [31:0] m0 = '0, m1 = '0, m2 = '0;
  logic [2:0]  grant, done;
  logic        fondos, busy;
  logic [63:0] balance;

  logic [2:0]  s_req = '0, s_tipo = '0;
  logic [31:0] s_m0 = '0;
  logic [2:0]  s_grant, s_done;
  logic        s_fondos, s_busy;
  logic [63:0] s_balance;

  int checks = 0;
  int errors = 0;

  balance_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .tipo_trans(tipo),
    .monto_0(m0), .monto_1(m1), .monto_2(m2),
    .grant(grant), .done(done), .fondos_insuficientes(fondos),
    .balance(balance), .busy(busy)
  );

  balance_arbiter #(.INIT_BALANCE(SAT_INIT)) sat_dut (
    .clk(clk), .rst(rst), .req(s_req), .tipo_trans(s_tipo),
    .monto_0(s_m0), .monto_1(32'd0), .monto_2(32'd0),
    .grant(s_grant), .done(s_done), .fondos_insuficientes(s_fondos),
    .balance(s_balance), .busy(s_busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner = terminal holding the balance (-1 when free),
  // age = edges since the grant was issued.
  int          m_owner = -1;
  int          m_age   = 0;
  int          m_last  = 2;
  logic [63:0] m_bal   = 64'd4500;
  logic        m_fond  = 1'b0;
  logic        m_tipo  = 1'b0;
  logic [31:0] m_amt   = '0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_owner = -1; m_age = 0; m_last = 2; m_bal = 64'd4500; m_fond = 1'b0;
    end else if (m_owner < 0) begin
      int w;
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
      if (w >= 0) begin
        m_owner = w; m_age = 0; m_last = w;
        m_tipo  = tipo[w];
        m_amt   = (w == 0) ? m0 : (w == 1) ? m1 : m2;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      if (!m_tipo) begin
        m_fond = 1'b0;
        if (m_bal > MAXV - {32'd0, m_amt}) m_bal = MAXV;
        else m_bal = m_bal + {32'd0, m_amt};
      end else if ({32'd0, m_amt} > m_bal) begin
        m_fond = 1'b1;
      end else begin
        m_fond = 1'b0;
        m_bal  = m_bal - {32'd0, m_amt};
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_fond = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  initial forever begin
    logic [2:0] e_grant, e_done;
    @(negedge clk);
    e_grant = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    e_done  = (m_owner >= 0 && m_age >= 1) ? e_grant : 3'b000;
    chk("model_grant", {61'd0, grant}, {61'd0, e_grant});
    chk("model_done", {61'd0, done}, {61'd0, e_done});
    chk("model_busy", {63'd0, busy}, {63'd0, (m_owner >= 0)});
    chk("model_balance", balance, m_bal);
    if (e_done != 0) chk("model_fondos", {63'd0, fondos}, {63'd0, m_fond});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; s_req = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic set_op(input int t, input logic tp, input logic [31:0] amt);
    tipo[t] = tp;
    case (t)
      0: m0 = amt;
      1: m1 = amt;
      default: m2 = amt;
    endcase
    req[t] = 1'b1;
  endtask

  task automatic sat_dep(input logic [31:0] amt);
    int n;
    s_tipo[0] = 1'b0; s_m0 = amt; s_req[0] = 1'b1;
    n = 0;
    while (!s_done[0] && n < 10) begin tick(); n++; end
    if (!s_done[0]) timeout("sat_done");
    s_req[0] = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_amt();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return (m_bal < 64'h1_0000_0000) ? m_bal[31:0] : $urandom;
      3: return (m_bal < 64'hFFFF_FFFF) ? m_bal[31:0] + 32'd1 : $urandom;
      default: return 32'($urandom_range(0, 8000));
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    #1 rst = 1'b0;
    do_reset();
    chk("rst_grant", {61'd0, grant}, 64'd0);
    chk("rst_done", {61'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_fondos", {63'd0, fondos}, 64'd0);
    chk("rst_balance", balance, 64'd4500);

    // Deposit 500 on terminal 0
    set_op(0, 1'b0, 32'd500);
    tick(); chk("dep_grant", {61'd0, grant}, 64'b001); chk("dep_busy", {63'd0, busy}, 64'd1);
    tick(); chk("dep_balance", balance, 64'd5000); chk("dep_done", {61'd0, done}, 64'b001);
    chk("dep_fondos", {63'd0, fondos}, 64'd0);
    req[0] = 1'b0;
    tick(); chk("dep_idle_grant", {61'd0, grant}, 64'd0); chk("dep_idle_busy", {63'd0, busy}, 64'd0);

    // Exact withdrawal on terminal 1
    do_reset();
    set_op(1, 1'b1, 32'd4500);
    tick(); chk("wexact_grant", {61'd0, grant}, 64'b010);
    tick(); chk("wexact_balance", balance, 64'd0); chk("wexact_done", {61'd0, done}, 64'b010);
    chk("wexact_fondos", {63'd0, fondos}, 64'd0);
    req[1] = 1'b0; tick();

    // Insufficient withdrawal on terminal 2, held for several cycles
    do_reset();
    set_op(2, 1'b1, 32'd4501);
    tick(); tick();
    chk("winsuf_balance", balance, 64'd4500); chk("winsuf_done", {61'd0, done}, 64'b100);
    chk("winsuf_fondos", {63'd0, fondos}, 64'd1);
    tick(); tick(); tick();
    chk("winsuf_hold_done", {61'd0, done}, 64'b100); chk("winsuf_hold_fondos", {63'd0, fondos}, 64'd1);
    req[2] = 1'b0;
    tick(); chk("winsuf_clr_done", {61'd0, done}, 64'd0); chk("winsuf_clr_fondos", {63'd0, fondos}, 64'd0);

    // Zero-amount withdrawal completes cleanly
    set_op(0, 1'b1, 32'd0);
    tick(); tick();
    chk("zero_balance", balance, 64'd4500); chk("zero_fondos", {63'd0, fondos}, 64'd0);
    chk("zero_done", {61'd0, done}, 64'b001);
    req[0] = 1'b0; tick();

    // Request dropped during GRANT still completes; inputs changed after latch ignored
    do_reset();
    set_op(1, 1'b0, 32'd250);
    tick(); req[1] = 1'b0;
    tick(); chk("drop_done", {61'd0, done}, 64'b010); chk("drop_balance", balance, 64'd4750);
    tick(); chk("drop_idle", {61'd0, grant}, 64'd0);
    set_op(0, 1'b0, 32'd100);
    tick(); m0 = 32'd9999; tipo[0] = 1'b1;
    tick(); chk("latch_balance", balance, 64'd4850);
    req[0] = 1'b0; tick();

    // Round-robin with all three requesting
    do_reset();
    tipo = 3'b000; m0 = 32'd1; m1 = 32'd1; m2 = 32'd1; req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin tick(); n++; end while (grant == 0 && n < 10);
      chk("rr_order", {61'd0, grant}, {61'd0, order[k]});
      n = 0;
      while (done == 0 && n < 10) begin tick(); n++; end
      if (done == 0) timeout("rr_done");
      req = req & ~grant;
      n = 0;
      while (grant != 0 && n < 10) begin tick(); n++; end
      if (grant != 0) timeout("rr_release");
      req = 3'b111;
    end
    req = '0; tick(); tick();

    // Reset asserted during GRANT of a 1000 deposit
    do_reset();
    set_op(0, 1'b0, 32'd1000);
    tick(); chk("rstmid_grant_pre", {61'd0, grant}, 64'b001);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_grant", {61'd0, grant}, 64'd0); chk("rstmid_done", {61'd0, done}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0); chk("rstmid_balance", balance, 64'd4500);
    req = '0;
    tick(); tick();
    rst = 1'b1;

    // Saturation on the second instance
    do_reset();
    chk("sat_init", s_balance, SAT_INIT);
    for (int k = 0; k < 3; k++) sat_dep(32'hFFFF_FFFF);
    chk("sat_near", s_balance, 64'hFFFF_FFFF_FFFF_FF9B);
    s_tipo[0] = 1'b0; s_m0 = 32'hFFFF_FFFF; s_req[0] = 1'b1;
    tick(); tick();
    chk("sat_balance", s_balance, MAXV); chk("sat_done", {61'd0, s_done}, 64'b001);
    chk("sat_fondos", {63'd0, s_fondos}, 64'd0);
    s_req[0] = 1'b0; tick();
    sat_dep(32'd5);
    chk("sat_hold", s_balance, MAXV);

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if ($urandom % 600 == 0) begin
        rst = 1'b0; req = '0;
        tick();
        rst = 1'b1;
        continue;
      end
      for (int t = 0; t < 3; t++) begin
        if (req[t]) begin
          if ((done[t] || ($urandom % 16 == 0)) && ($urandom % 2 == 0)) req[t] = 1'b0;
          else if ($urandom % 8 == 0) begin
            tipo[t] = $urandom % 2;
            case (t) 0: m0 = $urandom; 1: m1 = $urandom; default: m2 = $urandom; endcase
          end
        end else if (!done[t] && ($urandom % 4 == 0)) begin
          set_op(t, 1'($urandom % 2), rand_amt());
        end
      end
    end
    req = '0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/balance_arbiter.md
BALANCE_ARBITER -- requirements
Module: balance_arbiter

Interface
REQ-001 Parameter: INIT_BALANCE, 4500, balance register value loaded on reset (64-bit).
REQ-002 Parameter: N_REQ, 3, number of terminal requesters (fixed at 3 in this revision).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  asynchronous reset, active-low.
REQ-006 Port: req  in  3  per-terminal transaction request, level, 4-phase handshake.
REQ-007 Port: tipo_trans  in  3  per-terminal op: 1 = withdrawal, 0 = deposit.
REQ-008 Port: monto_0, monto_1, monto_2  in  32 each  per-terminal amount, unsigned.
REQ-009 Port: grant  out  3  one-hot owner of the shared balance, all-zero when idle.
REQ-010 Port: done  out  3  per-terminal completion, one-hot, held until that terminal's req falls.
REQ-011 Port: fondos_insuficientes  out  1  withdrawal rejected; valid while any done bit is high.
REQ-012 Port: balance  out  64  current account balance, registered.
REQ-013 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, GRANT and RESP; all outputs SHALL be registered.
REQ-015 IDLE with req != 0 at an edge SHALL move to GRANT and set grant one-hot to the winner.
- The same edge SHALL latch the winner's tipo_trans and monto into internal registers.
REQ-016 Arbitration SHALL be round-robin.
- Search order starts at (last_winner+1) mod 3.
- last_winner SHALL update on each grant.
REQ-017 IDLE with req == 0 SHALL stay in IDLE with grant = 0 and done = 0.
REQ-018 GRANT SHALL last exactly one cycle and then move to RESP. On that edge:
- Deposit: balance += monto, zero-extended to 64 bits; if the sum overflows 64 bits, the balance SHALL saturate at 2^64-1.
- Withdrawal with monto <= balance: balance -= monto and fondos_insuficientes = 0.
- Withdrawal with monto > balance: balance unchanged and fondos_insuficientes = 1.
- done[winner] SHALL be set to 1.
REQ-019 A zero amount SHALL complete normally, with balance unchanged and fondos_insuficientes = 0.
REQ-020 A withdrawal with monto equal to balance SHALL succeed and leave balance = 0.
REQ-021 RESP SHALL hold grant, done and fondos_insuficientes until req[winner] is sampled low.
- That edge SHALL clear grant, done and fondos_insuficientes and return the FSM to IDLE.
REQ-022 Latency: req sampled at edge E0 gives grant after E0, and the updated balance and done after E0+1.
REQ-023 Dropping req[winner] during GRANT SHALL NOT abort the transaction.
- The latched operands SHALL complete.
- RESP SHALL exit on the first edge at which req[winner] is low.
REQ-024 Changes to requester inputs after the latch edge SHALL NOT affect the transaction in progress.
REQ-025 Requests from non-winning terminals SHALL be held pending and not dropped.
- They SHALL be arbitrated on the next IDLE edge.
REQ-026 At most one grant bit and at most one done bit SHALL be high in any cycle.
REQ-027 busy SHALL be 0 in IDLE and 1 in GRANT and RESP.

Reset
REQ-028 While rst is low, all of the following SHALL hold asynchronously:
- FSM = IDLE.
- grant = 0, done = 0, fondos_insuficientes = 0, busy = 0.
- balance = INIT_BALANCE.
- last_winner = 2, so terminal 0 has highest priority first.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction without applying its update, and SHALL restore balance to INIT_BALANCE.
REQ-030 After rst rises, the first arbitration SHALL occur at the first clk edge with req != 0.

Verification
REQ-031 Deposit: reset, then req[0] with tipo 0 and monto 500.
- Response: grant = 001 after 1 edge; balance = 5000, done = 001 and fondos = 0 after 2 edges; idle after req[0] drops.
REQ-032 Withdrawal, exact: from 4500, req[1] with tipo 1 and monto 4500 -> balance = 0, done = 010, fondos = 0.
REQ-033 Withdrawal, insufficient: from 4500, req[2] with tipo 1 and monto 4501.
- Response: balance stays 4500; done = 100 and fondos = 1 held until req[2] drops.
REQ-034 Round-robin: req = 111 held and each done acknowledged.
- Response: grant order 001, 010, 100, 001; no bit granted twice in a row while others are pending.
REQ-035 Reset mid-operation: rst pulled low during GRANT of a 1000 deposit.
- Response: grant and done clear immediately; balance = 4500.
REQ-036 Saturation: balance forced near 2^64-1 by repeated max-amount deposits, then a deposit of 0xFFFFFFFF -> balance = 2^64-1, done asserted.
